// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions for the instruction fetch sequencer.
// Holds the address type, the NOP encoding and the fetch FSM state set.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] t_xlen;

  // addi x0, x0, 0 -- stands in for the instruction word of a faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: issues one memory request at a
// time, presents each returned word to decode, and handles redirects and faults.
module fetch_sequencer #(
  parameter int              XLEN     = fetch_sequencer_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_fault
);
  import fetch_sequencer_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic            req_valid_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_pc_r;
  logic [31:0]     out_instr_r;
  logic            out_fault_r;

  logic            cap_en_s;
  logic [XLEN-1:0] cap_pc_s;
  logic [31:0]     cap_instr_s;
  logic            cap_fault_s;
  logic            redir_mis_s;
  logic            busy_after_s;
  logic            restart_s;

  assign redir_mis_s = is_misaligned(redirect_pc[1:0]);

  // A request stays outstanding past this cycle if it is accepted now or its response has not yet come back
  assign busy_after_s = ((state_r == ST_REQ) && imem_req_ready) ||
                        (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !imem_rsp_valid);
  assign restart_s    = (state_r == ST_REQ) || (state_r == ST_WAIT) || (state_r == ST_DRAIN);

  // Next-state, next-pc and output-register capture decisions
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cap_en_s    = 1'b0;
    cap_pc_s    = pc_r;
    cap_instr_s = NOP_INSTR;
    cap_fault_s = 1'b1;
    if (redirect_valid) begin
      pc_nxt_s = redirect_pc;
      if (busy_after_s) begin
        state_nxt_s = ST_DRAIN;
      end else if (redir_mis_s) begin
        state_nxt_s = ST_OUT;
        cap_en_s    = 1'b1;
        cap_pc_s    = redirect_pc;
      end else if (restart_s || fetch_en) begin
        state_nxt_s = ST_REQ;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_en) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_nxt_s = ST_OUT;
            pc_nxt_s    = pc_r + PC_STEP;
            cap_en_s    = 1'b1;
            cap_pc_s    = pc_r;
            cap_instr_s = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
            cap_fault_s = imem_rsp_err;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          // pc already holds the redirect target; a misaligned one becomes a fault entry
          if (imem_rsp_valid) begin
            if (is_misaligned(pc_r[1:0])) begin
              state_nxt_s = ST_OUT;
              cap_en_s    = 1'b1;
              cap_pc_s    = pc_r;
            end else begin
              state_nxt_s = ST_REQ;
            end
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_OUT: begin
          if (if_ready) begin
            if (out_fault_r) begin
              state_nxt_s = ST_FAULT;
            end else if (fetch_en) begin
              state_nxt_s = ST_REQ;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_OUT;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, pc and registered interface outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      req_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_pc_r    <= RESET_PC;
      out_instr_r <= 32'h0000_0000;
      out_fault_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      req_valid_r <= (state_nxt_s == ST_REQ);
      out_valid_r <= (state_nxt_s == ST_OUT);
      if (cap_en_s) begin
        out_pc_r    <= cap_pc_s;
        out_instr_r <= cap_instr_s;
        out_fault_r <= cap_fault_s;
      end
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign if_valid       = out_valid_r;
  assign if_pc          = out_pc_r;
  assign if_instr       = out_instr_r;
  assign if_fault       = out_fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level reference model
// tracking pending request, outstanding response, held entry and halt flags.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] WORD   = 32'h00A0_0093;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_fault(if_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // reference model: expected request, outstanding access, drop flag, pending fault, held entry, halted
  bit          m_req, m_out, m_disc, m_pend, m_entry, m_halt;
  logic [31:0] m_pc, e_pc, e_instr;
  bit          e_fault;

  // memory and stimulus knobs
  bit          mem_busy, stray;
  int          mem_dly;
  logic [31:0] mem_addr;
  int          k_ready, k_ifr, k_fe, k_redir, k_err, k_rst, k_maxdly;
  bit          k_fixed, log_addr;
  int          cyc, fe_cyc, first_valid;
  logic [31:0] addr_q[$];

  function automatic void model_reset();
    m_req = 0; m_out = 0; m_disc = 0; m_pend = 0; m_entry = 0; m_halt = 0;
    m_pc = RST_PC; e_pc = RST_PC; e_instr = 32'h0; e_fault = 0;
  endfunction

  function automatic void present(input logic [31:0] pc, input logic [31:0] instr, input bit fault);
    m_entry = 1; e_pc = pc; e_instr = instr; e_fault = fault;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (k_fixed) return WORD;
    return (a * 32'h9E37_79B9) ^ 32'h0000_0093;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] tbl [6] = '{32'h0000_0100, 32'h0000_0040, 32'h0000_0102,
                             32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0001};
    logic [31:0] r;
    int idx;
    idx = $urandom_range(7);
    r = $urandom();
    if (idx < 6) return tbl[idx];
    if (idx == 6) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic step();
    bit fe, rv, rdy, rsp, err, ifr, rst_v;
    logic [31:0] rpc, dat, o_pc;
    bit o_req, o_out, o_disc, o_pend, o_entry, o_halt, o_efault;
    bit idle_now, acc, got, hs, mis, busy_after;
    @(negedge clk);
    cyc++;
    check_eq("req_valid", 32'(imem_req_valid), 32'(m_req));
    if (m_req) check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("if_valid", 32'(if_valid), 32'(m_entry));
    if (m_entry) begin
      check_eq("if_pc", if_pc, e_pc);
      check_eq("if_instr", if_instr, e_instr);
      check_eq("if_fault", 32'(if_fault), 32'(e_fault));
    end
    if (if_valid && first_valid < 0) first_valid = cyc;

    rst_v = !($urandom_range(999) < 10 * k_rst);
    fe    = ($urandom_range(99) < k_fe);
    rdy   = ($urandom_range(99) < k_ready);
    ifr   = ($urandom_range(99) < k_ifr);
    rv    = ($urandom_range(99) < k_redir);
    rpc   = pick_target();
    rsp   = stray || (mem_busy && mem_dly == 0);
    dat   = rsp ? mem_word(mem_addr) : $urandom();
    err   = rsp && ($urandom_range(99) < k_err);
    rstn = rst_v; fetch_en = fe; imem_req_ready = rdy; if_ready = ifr;
    redirect_valid = rv; redirect_pc = rpc;
    imem_rsp_valid = rsp; imem_rsp_data = dat; imem_rsp_err = err;
    if (fe && fe_cyc < 0) fe_cyc = cyc;

    if (!rst_v) begin
      mem_busy = 0;
      stray = ($urandom_range(1) == 1);
    end else begin
      stray = 0;
      if (rsp) mem_busy = 0;
      else if (mem_busy) mem_dly--;
      if (imem_req_valid && rdy) begin
        mem_busy = 1;
        mem_dly  = $urandom_range(k_maxdly);
        mem_addr = imem_req_addr;
        if (log_addr) addr_q.push_back(imem_req_addr);
      end
    end

    if (!rst_v) begin
      model_reset();
    end else begin
      o_req = m_req; o_out = m_out; o_disc = m_disc; o_pend = m_pend;
      o_entry = m_entry; o_halt = m_halt; o_efault = e_fault; o_pc = m_pc;
      idle_now = !o_req && !o_out && !o_entry && !o_halt;
      acc = o_req && rdy;
      got = o_out && rsp;
      hs  = o_entry && ifr;
      if (idle_now && fe) m_req = 1;
      if (acc) begin m_req = 0; m_out = 1; end
      if (got) begin
        m_out = 0;
        if (o_disc) begin
          m_disc = 0;
          if (o_pend) begin m_pend = 0; present(o_pc, NOP, 1); end
          else m_req = 1;
        end else begin
          present(o_pc, err ? NOP : dat, err);
          m_pc = o_pc + 32'd4;
        end
      end
      if (hs) begin
        m_entry = 0;
        if (o_efault) m_halt = 1;
        else if (fe) m_req = 1;
      end
      if (rv) begin
        mis = (rpc[1:0] != 2'b00);
        busy_after = (o_out && !rsp) || acc;
        m_pc = rpc; m_entry = 0; m_halt = 0; m_req = 0;
        if (busy_after) begin
          m_out = 1; m_disc = 1; m_pend = mis;
        end else begin
          m_out = 0; m_disc = 0; m_pend = 0;
          if (mis) present(rpc, NOP, 1);
          else m_req = (o_req || o_out) ? 1'b1 : fe;
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0; if_ready = 1'b0;
    mem_busy = 0; stray = 0; mem_dly = 0; mem_addr = 32'h0;
    cyc = 0; fe_cyc = -1; first_valid = -1; log_addr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_if_fault", 32'(if_fault), 32'd0);
    check_eq("rst_if_pc", if_pc, RST_PC);

    // zero-wait streaming with decode always ready
    k_ready = 100; k_ifr = 100; k_fe = 100; k_redir = 0; k_err = 0; k_rst = 0;
    k_maxdly = 0; k_fixed = 1; log_addr = 1;
    repeat (12) step();
    log_addr = 0;
    check_eq("first_valid_latency", 32'(first_valid - fe_cyc), 32'd3);
    if (addr_q.size() < 3) begin
      check_eq("addr_count", 32'(addr_q.size()), 32'd3);
    end else begin
      check_eq("addr0", addr_q[0], 32'h0000_0000);
      check_eq("addr1", addr_q[1], 32'h0000_0004);
      check_eq("addr2", addr_q[2], 32'h0000_0008);
    end

    // decode stalls: the held entry must stay put with no new requests
    k_ifr = 0;
    repeat (10) step();
    k_ifr = 100;
    repeat (4) step();

    // random traffic with redirects, faults, back-pressure and resets
    k_ready = 70; k_ifr = 60; k_fe = 85; k_redir = 6; k_err = 8; k_rst = 1;
    k_maxdly = 3; k_fixed = 0;
    repeat (4000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
